// File: rtl/warp_xwb_pkg.sv
// Shared writeback types: register-address width, XLEN, source tags, FIFO entry.
package warp_xwb_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned XLEN   = 64;

  typedef enum logic [1:0] {
    WB_SRC_FIX = 2'd0,
    WB_SRC_MUL = 2'd1,
    WB_SRC_DIV = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/warp_xwb_fifo.sv
// Synchronous FIFO of writeback entries (rd + data); push/pop/head/count.
// Callers guarantee no pop when empty and no push when full without a pop.
module warp_xwb_fifo
  import warp_xwb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/warp_xwb.sv
// Integer writeback merge: fix -> rd1, mul -> rd2, buffered divide results
// drained into whichever slot is free; credit output gates divide issue.
module warp_xwb
  import warp_xwb_pkg::*;
#(
  parameter int unsigned DIV_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fix_valid,
  input  logic [REG_AW-1:0] i_fix_rd,
  input  logic [XLEN-1:0]   i_fix_data,
  input  logic              i_mul_valid,
  input  logic [REG_AW-1:0] i_mul_rd,
  input  logic [XLEN-1:0]   i_mul_data,
  input  logic              i_div_issue,
  input  logic              i_div_valid,
  input  logic [REG_AW-1:0] i_div_rd,
  input  logic [XLEN-1:0]   i_div_data,
  output logic              o_div_ready,
  output logic              o_rd1_wen,
  output logic [REG_AW-1:0] o_rd1_addr,
  output logic [XLEN-1:0]   o_rd1_wdata,
  output logic              o_rd2_wen,
  output logic [REG_AW-1:0] o_rd2_addr,
  output logic [XLEN-1:0]   o_rd2_wdata,
  output logic              o_overflow
);

  localparam int unsigned DIV_AW = $clog2(DIV_DEPTH);

  logic [DIV_AW:0]   count;
  logic [DIV_AW:0]   reserved;
  logic [DIV_AW+1:0] occupancy;
  wb_entry_t         head;
  wb_entry_t         div_entry;

  logic fix_ok, mul_ok, div_ok, div_x0;
  logic empty, full, hazard, pop, push, drop, res_dec, err;

  assign div_entry = '{rd: i_div_rd, data: i_div_data};

  always_comb begin
    fix_ok    = i_fix_valid && (i_fix_rd != '0);
    mul_ok    = i_mul_valid && (i_mul_rd != '0);
    div_ok    = i_div_valid && (i_div_rd != '0);
    div_x0    = i_div_valid && (i_div_rd == '0);
    empty     = (count == '0);
    full      = (count == (DIV_AW+1)'(DIV_DEPTH));
    hazard    = (fix_ok && (head.rd == i_fix_rd)) || (mul_ok && (head.rd == i_mul_rd));
    pop       = !empty && !hazard && !(fix_ok && mul_ok);
    // no bypass: an empty FIFO never pops, so a same-cycle push just lands
    push      = div_ok && (!full || pop);
    drop      = div_ok && full && !pop;
    res_dec   = push || div_x0;
    occupancy = {1'b0, count} + {1'b0, reserved} - (DIV_AW+2)'(pop);
    o_div_ready = (occupancy < (DIV_AW+2)'(DIV_DEPTH));
    err       = drop || (i_div_valid && (reserved == '0)) || (i_div_issue && !o_div_ready);
  end

  warp_xwb_fifo #(
    .DEPTH(DIV_DEPTH)
  ) u_fifo (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .push       (push),
    .push_entry (div_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rd1_wen   <= 1'b0;
      o_rd1_addr  <= '0;
      o_rd1_wdata <= '0;
      o_rd2_wen   <= 1'b0;
      o_rd2_addr  <= '0;
      o_rd2_wdata <= '0;
      reserved    <= '0;
      o_overflow  <= 1'b0;
    end else begin
      o_rd1_wen   <= 1'b0;
      o_rd1_addr  <= '0;
      o_rd1_wdata <= '0;
      o_rd2_wen   <= 1'b0;
      o_rd2_addr  <= '0;
      o_rd2_wdata <= '0;
      if (fix_ok) begin
        o_rd1_wen   <= 1'b1;
        o_rd1_addr  <= i_fix_rd;
        o_rd1_wdata <= i_fix_data;
      end else if (pop && mul_ok) begin
        o_rd1_wen   <= 1'b1;
        o_rd1_addr  <= head.rd;
        o_rd1_wdata <= head.data;
      end
      if (mul_ok) begin
        o_rd2_wen   <= 1'b1;
        o_rd2_addr  <= i_mul_rd;
        o_rd2_wdata <= i_mul_data;
      end else if (pop) begin
        o_rd2_wen   <= 1'b1;
        o_rd2_addr  <= head.rd;
        o_rd2_wdata <= head.data;
      end
      if (i_div_issue && !res_dec && (reserved != (DIV_AW+1)'(DIV_DEPTH))) begin
        reserved <= reserved + 1'b1;
      end else if (res_dec && !i_div_issue && (reserved != '0)) begin
        reserved <= reserved - 1'b1;
      end
      o_overflow <= o_overflow | err;
    end
  end

endmodule
